alu_sequencer: RTL and testbench
================================

# alu_sequencer

Programmable successor to the fixed read/add/done control FSM. Steps through a small writable micro-program that drives the register-file read decoders (A, B), the write decoder (C) and the ALU operation select, with conditional branching on latched ALU flags, a start/busy/done handshake and a step-limit watchdog. It sits between the host/test logic and the register-file + ALU datapath. Decoder and ALU select widths, program depth and step limit are all parameters.

## Interface
- SELECTIONALU, 3, ALU op select width
- SELECTIONDECO, 3, decoder select width; must be ≥3 and 2^SELECTIONDECO ≥ PROG_DEPTH
- PROG_DEPTH, 8, micro-program entries; ADDR_W = clog2(PROG_DEPTH)
- MAX_STEPS, 255, maximum ISSUE cycles per run before timeout
- Word width W = 2 + SELECTIONALU + 3*SELECTIONDECO; layout MSB→LSB {kind[1:0], alu, decoA, decoB, decoC}
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- lowRst  in  1  async active-low reset
- start  in  1  run request, sampled in IDLE/DONE
- sOverflow, sCarry, sNegative, sZero  in  1 each  ALU flags, combinational from datapath
- progWe  in  1  program write strobe
- progAddr  in  ADDR_W  program write address
- progData  in  W  program word
- sSelDecoA, sSelDecoB, sSelDecoC  out  SELECTIONDECO  read A, read B, write select; C all-ones = no write
- sSelAlu  out  SELECTIONALU  ALU op
- busy  out  1  run in progress
- done  out  1  run finished
- timeout  out  1  last run ended by watchdog
- pc  out  ADDR_W  current program counter (debug)

## Operation
- kind 00 EXEC: read decoA, decoB; write decoC with ALU op alu.
- kind 01 BRANCH: cond = decoA[2:0]; target = decoB[ADDR_W-1:0]. Cond: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 V, 111 never. Tested against latched flags.
- kind 10 HALT; kind 11 NOP.
- States: IDLE, ISSUE, READ, EXEC, DONE. busy = ISSUE|READ|EXEC; done = DONE.
- IDLE: start → ISSUE, pc=0, step=0, flags cleared, timeout cleared.
- ISSUE: step+1. EXEC word → READ. BRANCH → pc = taken ? target : pc+1, stay. NOP → pc+1, stay. HALT → DONE.
- READ: A/B/alu from word, C all-ones → EXEC.
- EXEC: A/B/C/alu from word; flags {V,C,N,Z} latched at the edge leaving EXEC; pc+1 → ISSUE.
- IDLE, ISSUE and DONE outputs: A=0, B=0, C=all-ones, alu=0. Write select is never valid outside EXEC.
- pc increment from PROG_DEPTH-1: implicit HALT → DONE, timeout=0. Branch target ≥ PROG_DEPTH → DONE.
- Watchdog: entering ISSUE with step == MAX_STEPS → DONE, timeout=1.
- DONE: held until start; start restarts as from IDLE. Program retained.
- progWe honoured only when busy=0; ignored while busy. Write and start on the same edge: write lands, run uses new word.

## Timing
- Reset (async): state IDLE, pc=0, step=0, flags=0, busy=0, done=0, timeout=0, A=B=0, C=all-ones, alu=0. Every program entry is set to HALT.
- Outputs are a Moore function of registered state/pc/program. No combinational path from the flags to the outputs.
- start high at edge k in IDLE → ISSUE from k. EXEC instruction = 3 cycles. BRANCH/NOP = 1 cycle. HALT → DONE one cycle after its ISSUE.
- Branch immediately after EXEC sees the flags from that EXEC cycle.
- lowRst low mid-run: outputs return to reset values immediately, independent of clk.

## Test plan
- Program [0: EXEC alu=010 A=6 B=7 C=0; 1: HALT], start pulse → (A,B,C,alu) = (0,0,7,0), (6,7,7,2), (6,7,0,2), (0,0,7,0), then done=1 on 5th cycle after start. C=0 only in EXEC cycle.
- [0: EXEC; 1: BRANCH cond=001 target=3; 2: HALT; 3: NOP; 4: HALT]: sZero=1 during EXEC → pc sequence 0,0,0,1,3,4 with timeout=0. sZero=0 → pc goes 1→2 → DONE.
- MAX_STEPS=16, [0: BRANCH always target 0] → DONE after 16 ISSUE cycles, timeout=1, busy falls with done rising.
- PROG_DEPTH=4, all NOP → DONE after 4 ISSUE cycles, pc wraps to 0 internally, timeout=0.
- progWe to entry 0 while busy → entry unchanged. Same write in DONE, then start → new word executes.
- lowRst pulsed low during EXEC → immediately C=all-ones, busy=0. Subsequent start → immediate DONE (all entries HALT).

Source files
------------

// File: rtl/alu_sequencer.sv
// Micro-programmed controller for the register-file + ALU datapath: sequences read/write
// decoder and ALU selects from a writable program, with flag branches and a step watchdog.
module alu_sequencer #(
    parameter int unsigned SELECTIONALU  = 3,
    parameter int unsigned SELECTIONDECO = 3,
    parameter int unsigned PROG_DEPTH    = 8,
    parameter int unsigned MAX_STEPS     = 255,
    localparam int unsigned ADDR_W       = $clog2(PROG_DEPTH),
    localparam int unsigned W            = 2 + SELECTIONALU + 3 * SELECTIONDECO
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic                     start,
    input  logic                     sOverflow,
    input  logic                     sCarry,
    input  logic                     sNegative,
    input  logic                     sZero,
    input  logic                     progWe,
    input  logic [ADDR_W-1:0]        progAddr,
    input  logic [W-1:0]             progData,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [ADDR_W-1:0]        pc
);

    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
    localparam int unsigned SD     = SELECTIONDECO;
    localparam logic [1:0]  K_EXEC   = 2'b00;
    localparam logic [1:0]  K_BRANCH = 2'b01;
    localparam logic [1:0]  K_HALT   = 2'b10;
    localparam logic [W-1:0] HALT_WORD = {K_HALT, {(W-2){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, READ, EXEC, DONE} state_t;

    state_t              state, stateNext;
    logic [ADDR_W-1:0]   pcNext, pcInc, target;
    logic [STEP_W-1:0]   step, stepNext;
    logic [3:0]          flags, flagsNext;       // {V, C, N, Z}
    logic                timeoutNext, advance, taken, lastPc, targetOk;
    logic [W-1:0]        prog [PROG_DEPTH];
    logic [W-1:0]        word;
    logic [1:0]          kind;
    logic [SELECTIONALU-1:0] wAlu, aluNext;
    logic [SD-1:0]       wA, wB, wC, selANext, selBNext, selCNext;
    logic                busyNext, doneNext;

    assign word     = prog[pc];
    assign kind     = word[W-1 -: 2];
    assign wAlu     = word[3*SD +: SELECTIONALU];
    assign wA       = word[2*SD +: SD];
    assign wB       = word[SD +: SD];
    assign wC       = word[0 +: SD];
    assign target   = wB[ADDR_W-1:0];
    assign targetOk = 32'(target) < PROG_DEPTH;
    assign pcInc    = pc + ADDR_W'(1);
    assign lastPc   = pc == ADDR_W'(PROG_DEPTH - 1);

    // Program store; writes only land while no run is in progress
    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            for (int i = 0; i < int'(PROG_DEPTH); i++) prog[i] <= HALT_WORD;
        end else if (progWe && !busy && 32'(progAddr) < PROG_DEPTH) begin
            prog[progAddr] <= progData;
        end
    end

    // Branch condition against the flags latched by the last EXEC
    always_comb begin
        taken = 1'b0;
        case (wA[2:0])
            3'b000:  taken = 1'b1;
            3'b001:  taken = flags[0];
            3'b010:  taken = !flags[0];
            3'b011:  taken = flags[2];
            3'b100:  taken = !flags[2];
            3'b101:  taken = flags[1];
            3'b110:  taken = flags[3];
            default: taken = 1'b0;
        endcase
    end

    // State register with registered outputs
    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            state     <= IDLE;
            pc        <= '0;
            step      <= '0;
            flags     <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sSelDecoA <= '0;
            sSelDecoB <= '0;
            sSelDecoC <= '1;
            sSelAlu   <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            step      <= stepNext;
            flags     <= flagsNext;
            timeout   <= timeoutNext;
            busy      <= busyNext;
            done      <= doneNext;
            sSelDecoA <= selANext;
            sSelDecoB <= selBNext;
            sSelDecoC <= selCNext;
            sSelAlu   <= aluNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        stepNext    = step;
        flagsNext   = flags;
        timeoutNext = timeout;
        advance     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext   = ISSUE;
                    pcNext      = '0;
                    stepNext    = '0;
                    flagsNext   = '0;
                    timeoutNext = 1'b0;
                end
            end
            ISSUE: begin
                stepNext = step + STEP_W'(1);
                case (kind)
                    K_EXEC:   stateNext = READ;
                    K_BRANCH: begin
                        if (!taken) begin
                            advance = 1'b1;
                        end else if (targetOk) begin
                            pcNext = target;
                        end else begin
                            stateNext = DONE;
                        end
                    end
                    K_HALT:   stateNext = DONE;
                    default:  advance = 1'b1;
                endcase
            end
            READ: stateNext = EXEC;
            EXEC: begin
                flagsNext = {sOverflow, sCarry, sNegative, sZero};
                advance   = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
        // Falling off the end of the program is an ordinary halt
        if (advance) begin
            if (lastPc) begin
                pcNext    = '0;
                stateNext = DONE;
            end else begin
                pcNext    = pcInc;
                stateNext = ISSUE;
            end
        end
        if (stateNext == ISSUE && stepNext == STEP_W'(MAX_STEPS)) begin
            stateNext   = DONE;
            timeoutNext = 1'b1;
        end
    end

    // Output values for the state being entered; write select only valid in EXEC
    always_comb begin
        selANext = '0;
        selBNext = '0;
        selCNext = '1;
        aluNext  = '0;
        if (stateNext == READ || stateNext == EXEC) begin
            selANext = wA;
            selBNext = wB;
            aluNext  = wAlu;
        end
        if (stateNext == EXEC) selCNext = wC;
        busyNext = (stateNext == ISSUE) || (stateNext == READ) || (stateNext == EXEC);
        doneNext = stateNext == DONE;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer: default instance plus a small
// PROG_DEPTH=4 / MAX_STEPS=16 instance for wrap and watchdog behaviour.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        lowRst;
    logic        sOverflow, sCarry, sNegative, sZero;
    logic        start, progWe;
    logic [2:0]  progAddr;
    logic [13:0] progData;
    logic [2:0]  selA, selB, selC, selAlu, pc;
    logic        busy, done, timeout;

    logic        start2, progWe2;
    logic [1:0]  progAddr2;
    logic [13:0] progData2;
    logic [2:0]  selA2, selB2, selC2, selAlu2;
    logic [1:0]  pc2;
    logic        busy2, done2, timeout2;

    int checks = 0;
    int errors = 0;

    localparam logic [13:0] HALT = 14'b10_000_000_000_000;
    localparam logic [13:0] NOP  = 14'b11_000_000_000_000;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .lowRst(lowRst), .start(start),
        .sOverflow(sOverflow), .sCarry(sCarry), .sNegative(sNegative), .sZero(sZero),
        .progWe(progWe), .progAddr(progAddr), .progData(progData),
        .sSelDecoA(selA), .sSelDecoB(selB), .sSelDecoC(selC), .sSelAlu(selAlu),
        .busy(busy), .done(done), .timeout(timeout), .pc(pc)
    );

    alu_sequencer #(.PROG_DEPTH(4), .MAX_STEPS(16)) dut2 (
        .clk(clk), .lowRst(lowRst), .start(start2),
        .sOverflow(sOverflow), .sCarry(sCarry), .sNegative(sNegative), .sZero(sZero),
        .progWe(progWe2), .progAddr(progAddr2), .progData(progData2),
        .sSelDecoA(selA2), .sSelDecoB(selB2), .sSelDecoC(selC2), .sSelAlu(selAlu2),
        .busy(busy2), .done(done2), .timeout(timeout2), .pc(pc2)
    );

    function automatic logic [13:0] mk(input logic [1:0] k, input logic [2:0] alu,
                                       input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c);
        return {k, alu, a, b, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkOut(input string tag, input logic [11:0] exp);
        chk(tag, 32'({selA, selB, selC, selAlu}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [13:0] data);
        progWe = 1'b1; progAddr = addr; progData = data;
        tick();
        progWe = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] addr, input logic [13:0] data);
        progWe2 = 1'b1; progAddr2 = addr; progData2 = data;
        tick();
        progWe2 = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int pcsZ [6];
        int pcsNz [5];
        pcsZ  = '{0, 0, 0, 1, 3, 4};
        pcsNz = '{0, 0, 0, 1, 2};
        lowRst = 1'b1;
        start = 1'b0; progWe = 1'b0; progAddr = '0; progData = '0;
        start2 = 1'b0; progWe2 = 1'b0; progAddr2 = '0; progData2 = '0;
        sOverflow = 1'b0; sCarry = 1'b0; sNegative = 1'b0; sZero = 1'b0;
        #2 lowRst = 1'b0;
        #1;
        chkOut("rst_sel", {3'd0, 3'd0, 3'd7, 3'd0});
        chk("rst_flags", 32'({busy, done, timeout}), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        tick(); tick();
        lowRst = 1'b1;
        tick();

        // Single EXEC followed by HALT
        wr(3'd0, mk(2'b00, 3'd2, 3'd6, 3'd7, 3'd0));
        wr(3'd1, HALT);
        start = 1'b1;
        tick();
        start = 1'b0;
        chkOut("t1_issue", {3'd0, 3'd0, 3'd7, 3'd0});
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chkOut("t1_read", {3'd6, 3'd7, 3'd7, 3'd2});
        tick();
        chkOut("t1_exec", {3'd6, 3'd7, 3'd0, 3'd2});
        tick();
        chkOut("t1_issue2", {3'd0, 3'd0, 3'd7, 3'd0});
        chk("t1_pc_halt", 32'(pc), 32'd1);
        tick();
        chk("t1_done", 32'({busy, done, timeout}), 32'b010);
        chkOut("t1_done_sel", {3'd0, 3'd0, 3'd7, 3'd0});

        // Branch on Z latched from the preceding EXEC
        wr(3'd0, mk(2'b00, 3'd0, 3'd1, 3'd2, 3'd3));
        wr(3'd1, mk(2'b01, 3'd0, 3'b001, 3'd3, 3'd0));
        wr(3'd2, HALT);
        wr(3'd3, NOP);
        wr(3'd4, HALT);
        sZero = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            chk("t2z_pc", 32'(pc), 32'(pcsZ[i]));
        end
        tick();
        chk("t2z_done", 32'({done, timeout}), 32'b10);
        chk("t2z_pc_end", 32'(pc), 32'd4);
        sZero = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            chk("t2nz_pc", 32'(pc), 32'(pcsNz[i]));
        end
        tick();
        chk("t2nz_done", 32'({done, timeout}), 32'b10);
        chk("t2nz_pc_end", 32'(pc), 32'd2);

        // Program writes ignored while busy
        start = 1'b1;
        tick();
        start = 1'b0;
        progWe = 1'b1; progAddr = 3'd0; progData = HALT;
        tick();
        progWe = 1'b0;
        waitDone("t3_run1_done");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chkOut("t3_entry_kept", {3'd1, 3'd2, 3'd7, 3'd0});
        waitDone("t3_run2_done");

        // Write and start on the same edge: new word is used
        progWe = 1'b1; progAddr = 3'd0; progData = HALT; start = 1'b1;
        tick();
        progWe = 1'b0; start = 1'b0;
        chk("t4_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_done", 32'({busy, done}), 32'b01);
        chk("t4_pc", 32'(pc), 32'd0);

        // Async reset in the middle of EXEC
        wr(3'd0, mk(2'b00, 3'd2, 3'd6, 3'd7, 3'd0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chkOut("t5_exec", {3'd6, 3'd7, 3'd0, 3'd2});
        #2 lowRst = 1'b0;
        #1;
        chkOut("t5_rst_sel", {3'd0, 3'd0, 3'd7, 3'd0});
        chk("t5_rst_busy", 32'(busy), 32'd0);
        lowRst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_issue", 32'(busy), 32'd1);
        tick();
        chk("t5_halt_done", 32'({busy, done}), 32'b01);

        // Small instance: all-NOP program falls off the end
        for (int i = 0; i < 4; i++) wr2(2'(i), NOP);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (busy2 && n < 40) begin
            n++;
            tick();
        end
        chk("t6_nop_cycles", 32'(n), 32'd4);
        chk("t6_done", 32'({busy2, done2, timeout2}), 32'b010);
        chk("t6_pc_wrap", 32'(pc2), 32'd0);

        // Small instance: branch-always loop trips the watchdog
        wr2(2'd0, mk(2'b01, 3'd0, 3'b000, 3'd0, 3'd0));
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (busy2 && n < 40) begin
            n++;
            tick();
        end
        chk("t7_wd_cycles", 32'(n), 32'd16);
        chk("t7_wd_done", 32'({busy2, done2, timeout2}), 32'b011);

        // Timeout cleared by the next start
        wr2(2'd0, HALT);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t8_timeout_clr", 32'({busy2, timeout2}), 32'b10);
        tick();
        chk("t8_done", 32'({done2, timeout2}), 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
